// File: rtl/rv32i_defs.sv
// Shared definitions for the RV32I execute-stage ALU: opcode encoding and
// bit positions of the {n, z, c, v} status flags.
package rv32i_defs;

   typedef enum logic [3:0] {
      SUM  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      SLL  = 4'd5,
      SRL  = 4'd6,
      SRA  = 4'd7,
      SLT  = 4'd8,
      SLTU = 4'd9
   } alu_opcode;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for the ALU: all three shift flavours of operand a by a
// 5-bit amount, selected downstream by the opcode case.
module alu_shifter (
   input  logic [31:0] a,
   input  logic [4:0]  shamt,
   output logic [31:0] sll_res,
   output logic [31:0] srl_res,
   output logic [31:0] sra_res
);

   always_comb begin
      sll_res = a << shamt;
      srl_res = a >> shamt;
      sra_res = $signed(a) >>> shamt;
   end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I integer ALU: combinational result and NZCV status, plus a registered
// copy of the status for consumers in later cycles.
module rv32i_alu
   import rv32i_defs::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_opcode   operation,
   output logic [31:0] result,
   output logic [3:0]  status,
   output logic [3:0]  status_q
);

   logic        sub_sel;
   logic [31:0] b_eff;
   logic [32:0] sum;
   logic        add_v;
   logic [31:0] sll_res;
   logic [31:0] srl_res;
   logic [31:0] sra_res;
   logic [31:0] result_d;
   logic        c_d;
   logic        v_d;
   logic [3:0]  status_d;

   alu_shifter u_shifter (
      .a       (a),
      .shamt   (b[4:0]),
      .sll_res (sll_res),
      .srl_res (srl_res),
      .sra_res (sra_res)
   );

   // One adder serves SUM, SUB and both compares; compares reuse the subtract.
   always_comb begin
      sub_sel = (operation == SUB) || (operation == SLT) || (operation == SLTU);
      b_eff   = sub_sel ? ~b : b;
      sum     = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub_sel};
      add_v   = (a[31] == b_eff[31]) && (sum[31] != a[31]);
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      result_d = '0;
      c_d      = 1'b0;
      v_d      = 1'b0;
      case (operation)
         SUM, SUB: begin
            result_d = sum[31:0];
            c_d      = sum[32];
            v_d      = add_v;
         end
         AND:     result_d = a & b;
         OR:      result_d = a | b;
         XOR:     result_d = a ^ b;
         SLL:     result_d = sll_res;
         SRL:     result_d = srl_res;
         SRA:     result_d = sra_res;
         SLT:     result_d = {31'd0, sum[31] ^ add_v};
         SLTU:    result_d = {31'd0, ~sum[32]};
         default: result_d = '0;
      endcase

      status_d         = '0;
      status_d[FLAG_N] = result_d[31];
      status_d[FLAG_Z] = (result_d == '0);
      status_d[FLAG_C] = c_d;
      status_d[FLAG_V] = v_d;
   end

   assign result = result_d;
   assign status = status_d;

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // pre-edge values; the reset branch is asynchronous on rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
      end else begin
         status_q <= status_d;
      end
   end

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed vector table, randomized
// vectors against an arithmetic reference model, and status_q reset sequences.
module tb_rv32i_alu;
   import rv32i_defs::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   alu_opcode   operation;
   logic [31:0] result;
   logic [3:0]  status;
   logic [3:0]  status_q;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rv32i_alu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .operation (operation),
      .result    (result),
      .status    (status),
      .status_q  (status_q)
   );

   typedef struct {
      alu_opcode   op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_r;
      logic [3:0]  exp_st;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: signed/unsigned arithmetic in 64 bits, flags from range checks.
   function automatic void model(input alu_opcode op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [3:0] st);
      longint ux;
      longint uy;
      longint sx;
      longint sy;
      longint wide;
      longint max_s;
      longint min_s;
      int     sh;
      logic   c;
      logic   v;
      ux    = longint'(x);
      uy    = longint'(y);
      sx    = longint'($signed(x));
      sy    = longint'($signed(y));
      max_s = 64'sd2147483647;
      min_s = -max_s - 1;
      sh    = int'(y % 32);
      c     = 1'b0;
      v     = 1'b0;
      r     = '0;
      case (op)
         SUM: begin
            wide = ux + uy;
            r    = wide[31:0];
            c    = (wide >= (longint'(1) << 32));
            wide = sx + sy;
            v    = (wide > max_s) || (wide < min_s);
         end
         SUB: begin
            r    = x - y;
            c    = (ux >= uy);
            wide = sx - sy;
            v    = (wide > max_s) || (wide < min_s);
         end
         AND:  r = x & y;
         OR:   r = x | y;
         XOR:  r = x ^ y;
         SLL:  r = x << sh;
         SRL:  r = x >> sh;
         SRA:  r = $unsigned($signed(x) >>> sh);
         SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
         SLTU: r = (ux < uy) ? 32'd1 : 32'd0;
         default: r = '0;
      endcase
      st = {r[31], (r == 32'd0), c, v};
   endfunction

   vec_t vecs[16];

   task automatic apply_and_check(input string tag, input alu_opcode op, input logic [31:0] x,
                                  input logic [31:0] y, input logic [31:0] er, input logic [3:0] es);
      @(negedge clk);
      operation = op;
      a         = x;
      b         = y;
      #1;
      check({tag, " result"}, result, er);
      check({tag, " status"}, 32'(status), 32'(es));
      @(posedge clk);
      #1;
      check({tag, " status_q"}, 32'(status_q), 32'(es));
   endtask

   initial begin
      logic [31:0] mr;
      logic [3:0]  ms;
      alu_opcode   rop;

      vecs[0]  = '{SUM,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100};
      vecs[1]  = '{SUM,  32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000};
      vecs[2]  = '{SUM,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      vecs[3]  = '{SUM,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
      vecs[4]  = '{SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110};
      vecs[5]  = '{SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000};
      vecs[6]  = '{SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b1000};
      vecs[7]  = '{SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000};
      vecs[8]  = '{SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000};
      vecs[9]  = '{SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0100};
      vecs[10] = '{XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 4'b0000};
      vecs[11] = '{AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000};
      vecs[12] = '{OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 4'b0000};
      vecs[13] = '{SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 4'b0000};
      vecs[14] = '{SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
      vecs[15] = '{alu_opcode'(4'd12), 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0100};

      // Reset held: status_q stays clear even though status is nonzero.
      rst_n     = 1'b0;
      operation = SUM;
      a         = 32'h7FFF_FFFF;
      b         = 32'h0000_0001;
      repeat (2) @(posedge clk);
      #1;
      check("reset status_q", 32'(status_q), 32'h0);
      check("reset result", result, 32'h8000_0000);
      check("reset status", 32'(status), 32'(4'b1001));
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                         vecs[i].exp_r, vecs[i].exp_st);
      end

      // Reset asserted between edges clears status_q immediately.
      apply_and_check("pre_rst", SUM, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
      #2;
      rst_n = 1'b0;
      #1;
      check("midcycle rst status_q", 32'(status_q), 32'h0);
      check("midcycle rst result", result, 32'h8000_0000);
      @(posedge clk);
      #1;
      check("rst held status_q", 32'(status_q), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post rst status_q", 32'(status_q), 32'(4'b1001));

      for (int i = 0; i < 32; i++) begin
         rop = ($urandom_range(0, 1) == 1) ? SUB : SUM;
         a   = $urandom();
         b   = $urandom();
         model(rop, a, b, mr, ms);
         apply_and_check($sformatf("rand_addsub%0d", i), rop, a, b, mr, ms);
      end

      for (int i = 0; i < 32; i++) begin
         rop = alu_opcode'(4'($urandom_range(0, 9)));
         a   = $urandom();
         b   = ($urandom_range(0, 3) == 0) ? a : $urandom();
         model(rop, a, b, mr, ms);
         apply_and_check($sformatf("rand_any%0d", i), rop, a, b, mr, ms);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
